// File: rtl/track_conditioner.sv
// Line-tracking front end: 2-flop sync, per-channel debounce, change strobe, lost-line FSM.
// Define TRACK_INTEGRATOR_EN to make each debounce counter an up/down integrator.
module track_conditioner #(
    parameter int unsigned DEB_CYCLES  = 100000,
    parameter int unsigned LOST_CYCLES = 5000000,
    parameter int unsigned CNT_W       = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left_track,
    input  logic       mid_track,
    input  logic       right_track,
    output logic [2:0] track_clean,
    output logic       pattern_chg,
    output logic       lost,
    output logic [7:0] lost_cnt
);

    typedef enum logic [1:0] {TRACK, PEND, LOST} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOST_LAST = CNT_W'(LOST_CYCLES - 1);

    logic [2:0]            meta_q, meta_d;
    logic [2:0]            sync_q, sync_d;
    logic [2:0]            clean_q, clean_d;
    logic [2:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic                  pattern_chg_q, pattern_chg_d;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic [7:0]            lost_cnt_q, lost_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q        <= 3'b111;
            sync_q        <= 3'b111;
            clean_q       <= 3'b111;
            deb_cnt_q     <= '0;
            pattern_chg_q <= 1'b0;
            state_q       <= TRACK;
            timer_q       <= '0;
            lost_cnt_q    <= '0;
        end else begin
            meta_q        <= meta_d;
            sync_q        <= sync_d;
            clean_q       <= clean_d;
            deb_cnt_q     <= deb_cnt_d;
            pattern_chg_q <= pattern_chg_d;
            state_q       <= state_d;
            timer_q       <= timer_d;
            lost_cnt_q    <= lost_cnt_d;
        end
    end

    always_comb begin
        meta_d    = {left_track, mid_track, right_track};
        sync_d    = meta_q;
        clean_d   = clean_q;
        deb_cnt_d = deb_cnt_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (sync_q[i] != clean_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    clean_d[i]   = sync_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
                end
            end else begin
`ifdef TRACK_INTEGRATOR_EN
                if (deb_cnt_q[i] != '0) begin
                    deb_cnt_d[i] = deb_cnt_q[i] - CNT_W'(1);
                end
`else
                deb_cnt_d[i] = '0;
`endif
            end
        end
        // strobe is registered alongside clean so both become visible together
        pattern_chg_d = (clean_d != clean_q);
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        lost_cnt_d = lost_cnt_q;
        case (state_q)
            TRACK: begin
                if (clean_q == 3'b000) begin
                    state_d = PEND;
                    timer_d = '0;
                end
            end
            PEND: begin
                if (clean_q != 3'b000) begin
                    state_d = TRACK;
                end else if (timer_q == LOST_LAST) begin
                    state_d = LOST;
                    if (lost_cnt_q != 8'hFF) begin
                        lost_cnt_d = lost_cnt_q + 8'd1;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            LOST: begin
                if (clean_q != 3'b000) begin
                    state_d = TRACK;
                end
            end
            default: state_d = TRACK;
        endcase
    end

    // lost is decoded from the state register, so it changes on the transition edge
    always_comb begin
        track_clean = clean_q;
        pattern_chg = pattern_chg_q;
        lost        = (state_q == LOST);
        lost_cnt    = lost_cnt_q;
    end

endmodule

// File: tb/tb_track_conditioner.sv
// Bench for track_conditioner: directed plan steps plus random hold patterns,
// checked every cycle against a sliding-window / zero-run reference model.
module tb_track_conditioner;

    localparam int unsigned DEB   = 4;
    localparam int unsigned LOSTC = 10;
    localparam int unsigned CW    = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       left_track = 1'b1;
    logic       mid_track = 1'b1;
    logic       right_track = 1'b1;
    logic [2:0] track_clean;
    logic       pattern_chg;
    logic       lost;
    logic [7:0] lost_cnt;

    int n_pass  = 0;
    int n_total = 0;

    track_conditioner #(
        .DEB_CYCLES (DEB),
        .LOST_CYCLES(LOSTC),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .left_track (left_track),
        .mid_track  (mid_track),
        .right_track(right_track),
        .track_clean(track_clean),
        .pattern_chg(pattern_chg),
        .lost       (lost),
        .lost_cnt   (lost_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: raw is delayed two edges, a channel flips once the last DEB
    // synchronised samples all disagree with it; lost follows the length of the zero run.
    logic [2:0]  m_s1 = 3'b111;
    logic [2:0]  m_s2 = 3'b111;
    logic [2:0]  m_clean = 3'b111;
    logic        m_chg = 1'b0;
    logic        m_lost = 1'b0;
    int unsigned m_zrun = 0;
    int unsigned m_lcnt = 0;
    logic [2:0]  m_hist[$];
`ifdef TRACK_INTEGRATOR_EN
    int unsigned m_score[3] = '{0, 0, 0};
`endif

    always @(posedge clk or posedge rst) begin : model
        logic [2:0] nxt;
        if (rst) begin
            m_s1    = 3'b111;
            m_s2    = 3'b111;
            m_clean = 3'b111;
            m_chg   = 1'b0;
            m_lost  = 1'b0;
            m_zrun  = 0;
            m_lcnt  = 0;
            m_hist.delete();
`ifdef TRACK_INTEGRATOR_EN
            m_score = '{0, 0, 0};
`endif
        end else begin
            if (m_clean == 3'b000) m_zrun++;
            else m_zrun = 0;
            m_lost = (m_zrun > LOSTC);
            if (m_zrun == LOSTC + 1 && m_lcnt < 255) m_lcnt++;
            nxt = m_clean;
`ifdef TRACK_INTEGRATOR_EN
            for (int b = 0; b < 3; b++) begin
                if (m_s2[b] != m_clean[b]) begin
                    if (m_score[b] == DEB - 1) begin
                        nxt[b]     = m_s2[b];
                        m_score[b] = 0;
                    end else begin
                        m_score[b]++;
                    end
                end else if (m_score[b] > 0) begin
                    m_score[b]--;
                end
            end
`else
            m_hist.push_back(m_s2);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            for (int b = 0; b < 3; b++) begin
                bit all_mis;
                all_mis = (m_hist.size() == DEB);
                foreach (m_hist[k]) if (m_hist[k][b] == m_clean[b]) all_mis = 1'b0;
                if (all_mis) nxt[b] = ~m_clean[b];
            end
`endif
            m_chg   = (nxt != m_clean);
            m_clean = nxt;
            m_s2    = m_s1;
            m_s1    = {left_track, mid_track, right_track};
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_all();
        chk("track_clean", 8'(track_clean), 8'(m_clean));
        chk("pattern_chg", 8'(pattern_chg), 8'(m_chg));
        chk("lost", 8'(lost), 8'(m_lost));
        chk("lost_cnt", lost_cnt, 8'(m_lcnt));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic set_raw(input logic [2:0] v);
        {left_track, mid_track, right_track} = v;
    endtask

    task automatic wait_clean(input logic [2:0] v);
        int n;
        n = 0;
        while (track_clean !== v && n < 64) begin
            step(1);
            n++;
        end
        chk("wait_clean", 8'(track_clean), 8'(v));
    endtask

    initial begin
        int n;
        @(negedge clk);
        check_all();
        chk("rst_clean", 8'(track_clean), 8'h07);
        chk("rst_lost_cnt", lost_cnt, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step(50);
        chk("idle_clean", 8'(track_clean), 8'h07);

        // 111 -> 101 appears exactly DEB+2 edges later with one strobe
        set_raw(3'b101);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk("step_clean", 8'(track_clean), (k >= 6) ? 8'h05 : 8'h07);
            chk("step_chg", 8'(pattern_chg), (k == 6) ? 8'h01 : 8'h00);
        end

        set_raw(3'b111);
        wait_clean(3'b111);
        step(5);
        set_raw(3'b101);
        step(3);
        set_raw(3'b111);
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("glitch_clean", 8'(track_clean), 8'h07);
            chk("glitch_chg", 8'(pattern_chg), 8'h00);
        end

        set_raw(3'b101); step(1);
        set_raw(3'b101); step(1);
        set_raw(3'b111); step(1);
        set_raw(3'b101); step(1);
        set_raw(3'b101); step(1);
        set_raw(3'b111);
        step(12);
`ifndef TRACK_INTEGRATOR_EN
        chk("noisy_clean", 8'(track_clean), 8'h07);
`endif

        // lost timing and exit
        set_raw(3'b111);
        wait_clean(3'b111);
        set_raw(3'b000);
        wait_clean(3'b000);
        n = 0;
        while (lost !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        chk("lost_delay", 8'(n), 8'd11);
        chk("lost_cnt_first", lost_cnt, 8'd1);
        set_raw(3'b010);
        wait_clean(3'b010);
        chk("lost_hold", 8'(lost), 8'h01);
        step(1);
        chk("lost_exit", 8'(lost), 8'h00);

        for (int r = 0; r < 260; r++) begin
            set_raw(3'b000);
            step(20);
            set_raw(3'b010);
            step(8);
        end
        chk("lost_cnt_sat", lost_cnt, 8'd255);

        // reset while pending with timer at 7
        set_raw(3'b000);
        wait_clean(3'b000);
        step(8);
        rst = 1'b1;
        #1;
        check_all();
        chk("rst_pend_lost", 8'(lost), 8'h00);
        chk("rst_pend_clean", 8'(track_clean), 8'h07);
        chk("rst_pend_cnt", lost_cnt, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk("post_rst_clean", 8'(track_clean), (k >= 6) ? 8'h00 : 8'h07);
        end

        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 5) == 0) begin
                set_raw(3'b000);
                step(int'($urandom_range(10, 24)));
            end else begin
                set_raw(3'($urandom_range(0, 7)));
                step(int'($urandom_range(1, 9)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
